bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, sets the grant-hold watchdog limit in clock cycles (range 2..255).
REQ-003 Port clock, input, 1: rising-edge system clock.
REQ-004 Port clear, input, 1: asynchronous active-high reset.
REQ-005 Port req, input, 32: per-source bus-drive requests; bit i is source i (R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C, spares).
REQ-006 Port release, input, 1: single-cycle pulse from the current grantee ending its bus tenure.
REQ-007 Port grant, output, 32: registered one-hot (or zero) bus-drive vector, feeding the 32-to-5 bus-select encoder.
REQ-008 Port busy, output, 1: high while grant is nonzero.
REQ-009 Port timeout, output, 1: single-cycle pulse when the watchdog revokes a grant (see Configuration).

Function
REQ-010 The block SHALL implement a two-state FSM, IDLE and GRANTED.
REQ-011 In IDLE with req nonzero at a rising edge, the block SHALL move to GRANTED and assert grant bit k on that edge: one cycle of latency from request to grant.
REQ-012 Bit k SHALL be the first set req bit found searching upward from pointer ptr (5 bits), wrapping from 31 to 0.
REQ-013 In IDLE with req zero, grant SHALL remain zero and ptr SHALL remain unchanged.
REQ-014 In GRANTED, grant SHALL hold constant regardless of changes on other req bits.
REQ-015 In GRANTED, release high or req[k] low at an edge SHALL clear grant on that edge, return the FSM to IDLE, and load ptr with k+1 modulo 32 (grantee 31 wraps ptr to 0).
REQ-016 Release and req[k] falling in the same cycle SHALL count as one tenure end, with no extra effect.
REQ-017 Release in IDLE SHALL be ignored.
REQ-018 Every tenure SHALL be followed by at least one IDLE cycle (grant all-zero), so the earliest re-grant is two edges after release.
REQ-019 grant SHALL never have more than one bit set in any cycle.
REQ-020 busy SHALL equal the OR-reduction of grant and SHALL be driven from state, not from req.

Reset
REQ-021 Asserting clear SHALL immediately set grant=0, busy=0, timeout=0, ptr=0, the watchdog count to 0 and the FSM to IDLE, including in the middle of a grant.
REQ-022 After clear deasserts, the first grant SHALL go to the lowest-indexed active requester.

Configuration
REQ-023 With macro BUS_ARB_TIMEOUT_EN defined, an 8-bit watchdog SHALL count GRANTED cycles.
REQ-024 When the watchdog reaches TIMEOUT_CYCLES, the block SHALL clear grant, pulse timeout for one cycle, advance ptr to k+1, and return to IDLE, exactly as a release does.
REQ-025 Without BUS_ARB_TIMEOUT_EN, no watchdog logic SHALL exist, timeout SHALL be tied to 0, and a grant SHALL persist until release or until req[k] falls.

Verification
REQ-026 Reset then req=32'h0000_0011 -> grant=32'h0000_0001 one edge later; release -> grant=0; next grant=32'h0000_0010.
REQ-027 req=32'h8000_0001 with ptr=0, hold it, release each tenure -> grants alternate 32'h1, 32'h8000_0000, 32'h1 (wrap-around from 31 to 0 verified).
REQ-028 Grant bit 5 active, then assert clear mid-grant -> grant=0 asynchronously, before the next edge; after clear, req=32'h20 -> grant=32'h20.
REQ-029 Grant bit 3 active, change req to 32'h8 | 32'hF0 -> grant stays 32'h8; drop req[3] -> grant=0 next edge, then 32'h10.
REQ-030 With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold req=32'h4 with no release -> grant revoked after 16 GRANTED cycles, timeout pulses once, and re-grant to 32'h4 occurs two edges later.
REQ-031 A continuous assertion SHALL check on every cycle of every test that grant is one-hot or zero and that busy equals the OR of grant.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin 32-source bus-drive arbiter with a registered one-hot grant.
// Optional grant-hold watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] req,
    input  logic        bus_release,
    output logic [31:0] grant,
    output logic        busy,
    output logic        timeout
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] GRANTED = 1'b1;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    logic [0:0] state;
    logic [4:0] ptr;
    logic [4:0] owner;
    logic [4:0] pick;
    logic       found;
    logic       wd_expire;
    logic       tenure_end;

    // Rotating priority search: first set req bit at or above ptr, wrapping 31 -> 0.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < 32; i++) begin
            if (!found && req[ptr + 5'(i)]) begin
                found = 1'b1;
                pick  = ptr + 5'(i);
            end
        end
    end

    assign tenure_end = bus_release || !req[owner] || wd_expire;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANTED;
                        grant <= 32'd1 << pick;
                        owner <= pick;
                    end
                end
                GRANTED: begin
                    if (tenure_end) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= owner + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign busy = |grant;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] wd_count;
    logic       timeout_q;

    // Expiry on the edge that would end the TIMEOUT_CYCLES-th granted cycle.
    assign wd_expire = (state == GRANTED) && (wd_count == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wd_count  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_expire;
            if (state == GRANTED && !tenure_end)
                wd_count <= wd_count + 8'd1;
            else
                wd_count <= '0;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; watchdog steps follow BUS_ARB_TIMEOUT_EN.
module tb_bus_arbiter;

    logic        clock;
    logic        clear;
    logic [31:0] req;
    logic        bus_release;
    logic [31:0] grant;
    logic        busy;
    logic        timeout;

    int vectors     = 0;
    int miscompares = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clock      (clock),
        .clear      (clear),
        .req        (req),
        .bus_release(bus_release),
        .grant      (grant),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [31:0] g);
        check(tag, grant, g);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, |g});
    endtask

    // Invariant checked every cycle: grant one-hot or zero, busy tracks grant.
    always @(negedge clock) begin
        if (!clear) begin
            vectors++;
            assert ($onehot0(grant) && (busy === |grant))
            else begin
                miscompares++;
                $error("FAIL onehot_busy: observed grant %h busy %b", grant, busy);
            end
        end
    end

    initial begin
        #100000;
        $fatal(1, "FAIL global_timeout: observed no finish expected finish");
    end

    initial begin
        clear       = 1'b1;
        req         = '0;
        bus_release = 1'b0;
        #2;
        expect_grant("reset_grant", 32'h0);
        check("reset_timeout", {31'd0, timeout}, 32'h0);
        cyc();
        cyc();
        clear = 1'b0;

        // Basic grant, release, round-robin advance
        req = 32'h0000_0011;
        cyc(); expect_grant("t1_first", 32'h0000_0001);
        bus_release = 1'b1;
        cyc(); expect_grant("t1_release", 32'h0);
        bus_release = 1'b0;
        cyc(); expect_grant("t1_next", 32'h0000_0010);
        req = 32'h0;
        cyc(); expect_grant("t1_req_drop", 32'h0);
        bus_release = 1'b1;
        cyc(); expect_grant("idle_release_ignored", 32'h0);
        bus_release = 1'b0;

        // Wrap-around 31 -> 0 from ptr = 0
        clear = 1'b1; #1; clear = 1'b0;
        req = 32'h8000_0001;
        cyc(); expect_grant("wrap_a", 32'h0000_0001);
        bus_release = 1'b1;
        cyc(); expect_grant("wrap_a_end", 32'h0);
        bus_release = 1'b0;
        cyc(); expect_grant("wrap_b", 32'h8000_0000);
        bus_release = 1'b1;
        cyc(); expect_grant("wrap_b_end", 32'h0);
        bus_release = 1'b0;
        cyc(); expect_grant("wrap_c", 32'h0000_0001);

        // Release and req drop together: one tenure end, ptr -> 1
        bus_release = 1'b1; req = 32'h0;
        cyc(); expect_grant("dual_end", 32'h0);
        bus_release = 1'b0;
        cyc(); expect_grant("idle_hold_a", 32'h0);
        cyc(); expect_grant("idle_hold_b", 32'h0);

        // Grant holds against other req changes; drop req[k]
        req = 32'h0000_0008;
        cyc(); expect_grant("hold_grant", 32'h0000_0008);
        req = 32'h0000_00F8;
        cyc(); expect_grant("hold_others_a", 32'h0000_0008);
        cyc(); expect_grant("hold_others_b", 32'h0000_0008);
        req = 32'h0000_00F0;
        cyc(); expect_grant("hold_drop", 32'h0);
        cyc(); expect_grant("hold_next", 32'h0000_0010);
        req = 32'h0;
        cyc(); expect_grant("hold_idle", 32'h0);

        // Asynchronous clear mid-grant
        req = 32'h0000_0020;
        cyc(); expect_grant("clr_grant", 32'h0000_0020);
        #2; clear = 1'b1;
        #1; expect_grant("clr_async", 32'h0);
        cyc();
        clear = 1'b0;
        cyc(); expect_grant("clr_regrant", 32'h0000_0020);
        req = 32'h0;
        cyc();

        // First grant after clear goes to lowest-indexed requester
        clear = 1'b1; #1; clear = 1'b0;
        req = 32'h4000_0030;
        cyc(); expect_grant("post_clear_lowest", 32'h0000_0010);
        req = 32'h0;
        cyc(); expect_grant("post_clear_drop", 32'h0);

        // Long hold: watchdog revoke if enabled, persistent grant otherwise
        clear = 1'b1; #1; clear = 1'b0;
        req = 32'h0000_0004;
        cyc(); expect_grant("wd_grant", 32'h0000_0004);
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            cyc();
            expect_grant("wd_hold", 32'h0000_0004);
            check("wd_no_pulse", {31'd0, timeout}, 32'h0);
        end
        cyc(); expect_grant("wd_revoke", 32'h0);
        check("wd_pulse", {31'd0, timeout}, 32'h1);
        cyc(); expect_grant("wd_regrant", 32'h0000_0004);
        check("wd_pulse_end", {31'd0, timeout}, 32'h0);
`else
        for (int i = 1; i < 24; i++) begin
            cyc();
            expect_grant("nowd_hold", 32'h0000_0004);
            check("nowd_timeout", {31'd0, timeout}, 32'h0);
        end
`endif
        req = 32'h0;
        cyc(); expect_grant("final_idle", 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
